// File: rtl/csr_pkg.sv
// csr_pkg: definitions shared by the CSR bus units.
//   - modify strobe codes (none / write / set bits / clear bits)
//   - bit positions inside the csr_uart STATUS register
//   - uart_state_t, the state encoding used by the UART TX and RX FSMs
package csr_pkg;

  localparam logic [2:0] CSR_MOD_NONE  = 3'd0;
  localparam logic [2:0] CSR_MOD_WRITE = 3'd1;
  localparam logic [2:0] CSR_MOD_SET   = 3'd2;
  localparam logic [2:0] CSR_MOD_CLEAR = 3'd3;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_TX_OVF   = 4;
  localparam int STAT_RX_OVR   = 5;
  localparam int STAT_RX_FERR  = 6;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: DEPTH-entry FIFO used for the UART TX and RX byte queues.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write strobe and data
//   pop, dout       read strobe and head data (dout is the head, valid when !empty)
//   full, empty     occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Push and pop in the same cycle are both honoured, even when full.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pop_ok   = pop & ~empty;
    // a full FIFO still accepts a byte when a slot frees up this same cycle
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/csr_uart.sv
// csr_uart: CSR-mapped UART with buffered serial TX and optional RX.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   addr          CSR address, registered every cycle
//   read, modify  strobes acting on the address registered the cycle before
//   wdata         write data qualified by modify
//   rdata, valid  registered response, one cycle after the strobe
//   txd           serial output, idles high
//   rxd           serial input (used only when CSR_UART_RX_EN is defined)
// Registers: DATA at BASE_ADDR, STATUS at BASE_ADDR+1.
// Build option: define CSR_UART_RX_EN to build the RX synchroniser, FSM and FIFO.
//
// state       | meaning
// UART_IDLE   | line idle, waiting for a byte (TX) or a falling edge (RX)
// UART_START  | start bit (RX: checked at half a bit period)
// UART_DATA   | 8 data bits, LSB first
// UART_STOP   | stop bit (RX: sampled at its centre, byte pushed next cycle)
module csr_uart
  import csr_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'hBC0,
  parameter int          CLK_DIV   = 8,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [11:0]       STAT_ADDR = BASE_ADDR + 12'd1;
  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_DIV / 2 - 1);

  logic [11:0] q_addr_q, q_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_ferr_q, rx_ferr_d;

  logic        hit_data, hit_stat, access;
  logic        data_wr, data_rd, stat_clr, stat_rd;
  logic [31:0] status;

  logic        tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_dout;
  logic        tx_ovf_set;

  logic        rx_empty, rx_ovr_set, rx_ferr_set;
  logic [7:0]  rx_head;

  logic        unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------- CSR decode ----------------
  always_comb begin
    q_addr_d = addr;
    hit_data = (q_addr_q == BASE_ADDR);
    hit_stat = (q_addr_q == STAT_ADDR);
    // modify codes 4-7 are not accesses at all
    access   = read | ((modify != CSR_MOD_NONE) && (modify <= CSR_MOD_CLEAR));
    data_wr  = hit_data && (modify == CSR_MOD_WRITE);
    data_rd  = hit_data && read;
    stat_clr = hit_stat && (modify == CSR_MOD_CLEAR);
    stat_rd  = hit_stat && read;
  end

  // ---------------- TX path ----------------
  uart_state_t        tx_state_q;
  logic [CNT_W-1:0]   tx_cnt_q;
  logic [2:0]         tx_bit_q;
  logic [7:0]         tx_sh_q;
  logic               txd_q;

  uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // pop from IDLE, or on the last STOP cycle so frames run back to back
  always_comb begin
    tx_pop = 1'b0;
    if (!tx_empty)
      tx_pop = (tx_state_q == UART_IDLE) ||
               ((tx_state_q == UART_STOP) && (tx_cnt_q == '0));
    tx_ovf_set = data_wr && tx_full && !tx_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        UART_IDLE: begin
          if (tx_pop) begin
            tx_state_q <= UART_START;
            tx_cnt_q   <= CNT_TOP;
            tx_sh_q    <= tx_dout;
            txd_q      <= 1'b0;
          end
        end
        UART_START: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= UART_DATA;
            tx_cnt_q   <= CNT_TOP;
            tx_bit_q   <= 3'd7;
            txd_q      <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= CNT_TOP;
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            if (tx_bit_q == '0) begin
              tx_state_q <= UART_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q - 3'd1;
              txd_q    <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (tx_cnt_q == '0) begin
            if (tx_pop) begin
              tx_state_q <= UART_START;
              tx_cnt_q   <= CNT_TOP;
              tx_sh_q    <= tx_dout;
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= UART_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        default: tx_state_q <= UART_IDLE;
      endcase
    end
  end

  assign txd = txd_q;

  // ---------------- RX path ----------------
`ifdef CSR_UART_RX_EN
  uart_state_t        rx_state_q;
  logic [CNT_W-1:0]   rx_cnt_q;
  logic [2:0]         rx_bit_q;
  logic [7:0]         rx_sh_q;
  logic               rx_push_q;
  logic               rx_s1_q, rx_s2_q, rx_s3_q;
  logic               rx_fall, rx_pop, rx_full;
  logic [7:0]         rx_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_fall     = rx_s3_q & ~rx_s2_q;
    rx_pop      = data_rd & ~rx_empty;
    rx_ovr_set  = rx_push_q & rx_full & ~rx_pop;
    rx_ferr_set = (rx_state_q == UART_STOP) && (rx_cnt_q == '0) && !rx_s2_q;
    rx_head     = rx_empty ? 8'h00 : rx_dout;
  end

  uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_q),
    .pop   (rx_pop),
    .din   (rx_sh_q),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // rx_sh_q is stable while the push is pending because the FSM sits in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= UART_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_push_q  <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state_q)
        UART_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= UART_START;
            rx_cnt_q   <= CNT_HALF;
          end
        end
        UART_START: begin
          if (rx_cnt_q == '0) begin
            if (rx_s2_q) begin
              rx_state_q <= UART_IDLE;
            end else begin
              rx_state_q <= UART_DATA;
              rx_cnt_q   <= CNT_TOP;
              rx_bit_q   <= 3'd7;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q <= CNT_TOP;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == '0) rx_state_q <= UART_STOP;
            else                rx_bit_q   <= rx_bit_q - 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_state_q <= UART_IDLE;
            rx_push_q  <= rx_s2_q;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        default: rx_state_q <= UART_IDLE;
      endcase
    end
  end
`else
  logic unused_rxd;
  assign unused_rxd  = rxd;
  assign rx_empty    = 1'b1;
  assign rx_head     = 8'h00;
  assign rx_ovr_set  = 1'b0;
  assign rx_ferr_set = 1'b0;
`endif

  // ---------------- flags and read mux ----------------
  // set wins over a same-cycle clear
  always_comb begin
    tx_ovf_d  = (tx_ovf_q  & ~(stat_clr & wdata[STAT_TX_OVF]))  | tx_ovf_set;
    rx_ovr_d  = (rx_ovr_q  & ~(stat_clr & wdata[STAT_RX_OVR]))  | rx_ovr_set;
    rx_ferr_d = (rx_ferr_q & ~(stat_clr & wdata[STAT_RX_FERR])) | rx_ferr_set;

    status                = '0;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_TX_EMPTY] = tx_empty;
    status[STAT_TX_BUSY]  = (tx_state_q != UART_IDLE) | tx_pop;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_TX_OVF]   = tx_ovf_q;
    status[STAT_RX_OVR]   = rx_ovr_q;
    status[STAT_RX_FERR]  = rx_ferr_q;

    valid_d = (hit_data | hit_stat) & access;
    rdata_d = '0;
    if (data_rd)      rdata_d = {rx_empty, 23'b0, rx_head};
    else if (stat_rd) rdata_d = status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_addr_q  <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      q_addr_q  <= q_addr_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_csr_uart.sv
module tb_csr_uart;

  localparam int          CLK_DIV = 8;
  localparam int          DEPTH   = 4;
  localparam int          FRAME   = 10 * CLK_DIV;
  localparam int          BIT_T   = CLK_DIV * 10;
  localparam logic [11:0] DATA_A  = 12'hBC0;
  localparam logic [11:0] STAT_A  = 12'hBC1;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        txd;
  logic        rxd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_uart #(.BASE_ADDR(12'hBC0), .CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .txd    (txd),
    .rxd    (rxd)
  );

  // addr in cycle N, strobe in N+1, response sampled in N+2
  task automatic csr_access(input logic [11:0] a, input logic rd, input logic [2:0] m,
                            input logic [31:0] wd, output logic [31:0] rv, output logic vv);
    @(negedge clk); addr = a; read = 1'b0; modify = 3'd0;
    @(negedge clk); addr = 12'h000; read = rd; modify = m; wdata = wd;
    @(negedge clk); read = 1'b0; modify = 3'd0; wdata = '0;
    rv = rdata; vv = valid;
  endtask

  // reference serial waveform: start, 8 data bits LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i < CLK_DIV) return 1'b0;
    if (i < 9 * CLK_DIV) return b[(i - CLK_DIV) / CLK_DIV];
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [31:0] r; logic v;
    rst = 1'b1; read = 1'b0; modify = 3'd0; wdata = '0; addr = '0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
    total++; if (valid !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_out got valid=%b rdata=%h exp 0/0", valid, rdata); end
    rst = 1'b0;
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (v !== 1'b1 || r !== 32'h0000_000A) begin
      bad++; $display("FAIL reset_status got valid=%b rdata=%h exp 1/0000000a", v, r); end
    @(negedge clk);
    total++; if (valid !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL valid_one_cycle got valid=%b rdata=%h exp 0/0", valid, rdata); end
    csr_access(12'hBC2, 1'b1, 3'd0, '0, r, v);
    total++; if (v !== 1'b0 || r !== 32'h0) begin
      bad++; $display("FAIL miss_addr got valid=%b rdata=%h exp 0/0", v, r); end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    logic [31:0] r; logic v; int nerr; int first;
    csr_access(DATA_A, 1'b0, 3'd1, {$urandom_range(0, 32'hFFFFFF), b}, r, v);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL tx_latency_early byte=%h got=%b exp=1", b, txd); end
    nerr = 0; first = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (txd !== frame_bit(b, i)) begin nerr++; if (first < 0) first = i; end
    end
    total++; if (nerr != 0) begin
      bad++; $display("FAIL tx_frame byte=%h errors=%0d first_cycle=%0d exp 0 errors", b, nerr, first); end
    @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL tx_after_frame got=%b exp=1", txd); end
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL tx_idle_status got=%h exp=0000000a", r); end
  endtask

  task automatic test_modify_ignored();
    logic [31:0] r; logic v; int nerr;
    csr_access(DATA_A, 1'b0, 3'd2, 32'h0000_00FF, r, v);
    csr_access(DATA_A, 1'b0, 3'd3, 32'h0000_0000, r, v);
    csr_access(STAT_A, 1'b0, 3'd2, 32'h0000_0070, r, v);
    nerr = 0;
    repeat (20) begin @(negedge clk); if (txd !== 1'b1) nerr++; end
    total++; if (nerr != 0) begin bad++; $display("FAIL mod_ignored_txd low_cycles=%0d exp 0", nerr); end
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL mod_ignored_status got=%h exp=0000000a", r); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [6];
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom_range(0, 255));
    fork
      begin : writer
        logic [31:0] r; logic v;
        for (int k = 0; k < 6; k++) csr_access(DATA_A, 1'b0, 3'd1, {24'h0, b[k]}, r, v);
        csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
        total++; if (r !== 32'h0000_001D) begin bad++; $display("FAIL tx_ovf_status got=%h exp=0000001d", r); end
        csr_access(STAT_A, 1'b0, 3'd3, 32'h0000_0010, r, v);
        csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
        total++; if (r !== 32'h0000_000D) begin bad++; $display("FAIL tx_ovf_clear got=%h exp=0000000d", r); end
      end
      begin : monitor
        int w; int nerr; int first;
        w = 0;
        do begin @(negedge clk); w++; end while (txd !== 1'b0 && w < 30);
        total++;
        if (txd !== 1'b0) begin
          bad++; $display("FAIL b2b_start_timeout got txd=%b exp=0 within 30 cycles", txd);
        end else begin
          nerr = 0; first = -1;
          for (int i = 0; i < 5 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (txd !== frame_bit(b[i / FRAME], i % FRAME)) begin nerr++; if (first < 0) first = i; end
          end
          if (nerr != 0) begin
            bad++; $display("FAIL b2b_frames errors=%0d first_cycle=%0d exp 0 errors", nerr, first); end
          nerr = 0;
          repeat (2 * FRAME) begin @(negedge clk); if (txd !== 1'b1) nerr++; end
          total++; if (nerr != 0) begin bad++; $display("FAIL b2b_dropped_sent low_cycles=%0d exp 0", nerr); end
        end
      end
    join
    begin
      logic [31:0] r; logic v;
      csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
      total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL b2b_final_status got=%h exp=0000000a", r); end
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] r; logic v;
    csr_access(DATA_A, 1'b0, 3'd1, 32'h0000_0000, r, v);
    repeat (30) @(negedge clk);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL midframe_low got=%b exp=0", txd); end
    #2 rst = 1'b1;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL async_reset_txd got=%b exp=1", txd); end
    @(negedge clk); rst = 1'b0;
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL post_reset_status got=%h exp=0000000a", r); end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    #3 rxd = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; #(BIT_T); end
    rxd = stop_bit; #(BIT_T);
    rxd = 1'b1; #(BIT_T);
    @(negedge clk);
  endtask

`ifdef CSR_UART_RX_EN
  task automatic test_rx_basic();
    logic [31:0] r; logic v;
    drive_frame(8'hA3, 1'b1);
    csr_access(DATA_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_00A3) begin bad++; $display("FAIL rx_a3 got=%h exp=000000a3", r); end
    csr_access(DATA_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL rx_empty_read got=%h exp=80000000", r); end
  endtask

  // sends n random frames; reference queue keeps at most DEPTH bytes
  task automatic test_rx_queue(input int n);
    logic [31:0] r; logic v; logic [7:0] q [$]; logic [7:0] b; logic ovr;
    ovr = 1'b0;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      drive_frame(b, 1'b1);
      if (q.size() < DEPTH) q.push_back(b); else ovr = 1'b1;
    end
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== (32'h0000_0002 | (ovr ? 32'h20 : 32'h0))) begin
      bad++; $display("FAIL rx_queue_status n=%0d got=%h exp=%h", n, r, 32'h2 | (ovr ? 32'h20 : 32'h0)); end
    while (q.size() > 0) begin
      b = q.pop_front();
      csr_access(DATA_A, 1'b1, 3'd0, '0, r, v);
      total++; if (r !== {24'h0, b}) begin bad++; $display("FAIL rx_queue_data got=%h exp=%h", r, {24'h0, b}); end
    end
    csr_access(DATA_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL rx_queue_drained got=%h exp=80000000", r); end
    csr_access(STAT_A, 1'b0, 3'd3, 32'h0000_0020, r, v);
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL rx_ovr_clear got=%h exp=0000000a", r); end
  endtask

  task automatic test_rx_glitch_ferr();
    logic [31:0] r; logic v;
    #3 rxd = 1'b0;
    #24 rxd = 1'b1;
    #(3 * BIT_T);
    @(negedge clk);
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL rx_glitch_status got=%h exp=0000000a", r); end
    drive_frame(8'($urandom_range(0, 255)), 1'b0);
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_004A) begin bad++; $display("FAIL rx_ferr_status got=%h exp=0000004a", r); end
    csr_access(STAT_A, 1'b0, 3'd3, 32'h0000_0040, r, v);
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL rx_ferr_clear got=%h exp=0000000a", r); end
  endtask
`else
  task automatic test_rx_disabled();
    logic [31:0] r; logic v;
    drive_frame(8'hA3, 1'b1);
    csr_access(DATA_A, 1'b1, 3'd0, '0, r, v);
    total++; if (v !== 1'b1 || r !== 32'h8000_0000) begin
      bad++; $display("FAIL rx_off_data got valid=%b rdata=%h exp 1/80000000", v, r); end
    drive_frame(8'($urandom_range(0, 255)), 1'b0);
    csr_access(STAT_A, 1'b1, 3'd0, '0, r, v);
    total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL rx_off_status got=%h exp=0000000a", r); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame(8'h55);
    test_single_frame(8'($urandom_range(0, 255)));
    test_modify_ignored();
    test_back_to_back();
    test_midframe_reset();
`ifdef CSR_UART_RX_EN
    test_rx_basic();
    test_rx_queue(3);
    test_rx_queue(DEPTH + 1);
    test_rx_glitch_ferr();
`else
    test_rx_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
